datapath_sequencer: RTL and testbench

- Control-unit stage that sits directly upstream of the Datapath and generates its per-cycle strobes: RAin, RBin, RZin, RAout, RBout, RZout, AddImmediate and RegisterAImmediate.
- Accepts one micro-op plus an 8-bit immediate through a start/busy/done handshake.
- Steps a Moore FSM through T-states, asserting at most one bus driver per cycle.
- Counts completed micro-ops for debug.

---
 rtl/datapath_sequencer.sv | 144 ++++++++++++++
 tb/tb_datapath_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - Moore sequencer generating per-cycle datapath strobes for one micro-op
//
// Ports:
//   clock              system clock, rising edge
//   clear              asynchronous active-low reset
//   start, op, imm     request handshake; op/imm latched when start is seen in IDLE
//   busy               high during T0..last T-state
//   done               one-cycle pulse after the last T-state
//   RAin/RBin/RZin     register load strobes
//   RAout/RBout/RZout  bus driver enables (at most one high)
//   AddImmediate       adder immediate operand
//   RegisterAImmediate immediate loaded into A
//   op_count           completed micro-ops, saturating
module datapath_sequencer #(
    parameter int IMM_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 busy,
    output logic                 done,
    output logic                 RAin,
    output logic                 RBin,
    output logic                 RZin,
    output logic                 RAout,
    output logic                 RBout,
    output logic                 RZout,
    output logic [IMM_WIDTH-1:0] AddImmediate,
    output logic [IMM_WIDTH-1:0] RegisterAImmediate,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_DONE
    } state_t;

    // Every op is a sequence of at most three primitive steps.
    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_LOAD_A,
        STEP_ADD,
        STEP_MOVE_ZB
    } step_t;

    localparam logic [1:0] OP_LDA    = 2'b00;
    localparam logic [1:0] OP_ADDB   = 2'b01;
    localparam logic [1:0] OP_LDADDB = 2'b10;
    localparam logic [1:0] OP_MOVZB  = 2'b11;

    state_t                 state_q;
    state_t                 state_d;
    step_t                  step;
    logic [1:0]             op_q;
    logic [IMM_WIDTH-1:0]   imm_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            imm_q    <= '0;
            op_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                op_q  <= op;
                imm_q <= imm;
            end
            if (state_q == S_DONE && op_count != '1) begin
                op_count <= op_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = (op_q == OP_ADDB || op_q == OP_LDADDB) ? S_T1 : S_DONE;
            S_T1:   state_d = (op_q == OP_LDADDB) ? S_T2 : S_DONE;
            S_T2:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Map (T-state, latched op) onto the primitive step to perform.
    always_comb begin
        step = STEP_NONE;
        case (state_q)
            S_T0: begin
                case (op_q)
                    OP_LDA:    step = STEP_LOAD_A;
                    OP_ADDB:   step = STEP_ADD;
                    OP_LDADDB: step = STEP_LOAD_A;
                    OP_MOVZB:  step = STEP_MOVE_ZB;
                    default:   step = STEP_NONE;
                endcase
            end
            S_T1: begin
                if (op_q == OP_ADDB)        step = STEP_MOVE_ZB;
                else if (op_q == OP_LDADDB) step = STEP_ADD;
            end
            S_T2: step = STEP_MOVE_ZB;
            default: step = STEP_NONE;
        endcase
    end

    always_comb begin
        busy               = (state_q == S_T0) || (state_q == S_T1) || (state_q == S_T2);
        done               = (state_q == S_DONE);
        RAin               = 1'b0;
        RBin               = 1'b0;
        RZin               = 1'b0;
        RAout              = 1'b0;
        RBout              = 1'b0;
        RZout              = 1'b0;
        AddImmediate       = '0;
        RegisterAImmediate = '0;
        case (step)
            STEP_LOAD_A: begin
                RAin               = 1'b1;
                RegisterAImmediate = imm_q;
            end
            STEP_ADD: begin
                RAout        = 1'b1;
                RZin         = 1'b1;
                AddImmediate = imm_q;
            end
            STEP_MOVE_ZB: begin
                RZout = 1'b1;
                RBin  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - randomized and directed bench for datapath_sequencer against a schedule model
module tb_datapath_sequencer;

    logic       clock;
    logic       clear;
    logic       start;
    logic [1:0] op;
    logic [7:0] imm;

    logic       busy, done, RAin, RBin, RZin, RAout, RBout, RZout;
    logic [7:0] AddImmediate, RegisterAImmediate;
    logic [15:0] op_count;

    logic       s_busy, s_done, s_RAin, s_RBin, s_RZin, s_RAout, s_RBout, s_RZout;
    logic [7:0] s_AddImmediate, s_RegisterAImmediate;
    logic [1:0] s_op_count;

    int n_vec = 0;
    int n_err = 0;
    bit started = 0;

    datapath_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .imm(imm),
        .busy(busy), .done(done), .RAin(RAin), .RBin(RBin), .RZin(RZin),
        .RAout(RAout), .RBout(RBout), .RZout(RZout),
        .AddImmediate(AddImmediate), .RegisterAImmediate(RegisterAImmediate),
        .op_count(op_count)
    );

    datapath_sequencer #(.IMM_WIDTH(8), .CNT_WIDTH(2)) dut_small (
        .clock(clock), .clear(clear), .start(start), .op(op), .imm(imm),
        .busy(s_busy), .done(s_done), .RAin(s_RAin), .RBin(s_RBin), .RZin(s_RZin),
        .RAout(s_RAout), .RBout(s_RBout), .RZout(s_RZout),
        .AddImmediate(s_AddImmediate), .RegisterAImmediate(s_RegisterAImmediate),
        .op_count(s_op_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Output word layout: [23]=busy [22]=done [21:16]={RAin,RBin,RZin,RAout,RBout,RZout}
    // [15:8]=AddImmediate [7:0]=RegisterAImmediate
    logic [23:0] dut_vec, small_vec;
    assign dut_vec   = {busy, done, RAin, RBin, RZin, RAout, RBout, RZout, AddImmediate, RegisterAImmediate};
    assign small_vec = {s_busy, s_done, s_RAin, s_RBin, s_RZin, s_RAout, s_RBout, s_RZout,
                        s_AddImmediate, s_RegisterAImmediate};

    function automatic logic [23:0] mk(input logic b, input logic d, input logic [5:0] c,
                                       input logic [7:0] a, input logic [7:0] r);
        return {b, d, c, a, r};
    endfunction

    // Reference model: a queue of the output words still to be shown for the
    // accepted op, ending with the done word. Empty queue means idle.
    logic [23:0] sched[$];
    int          cnt = 0;

    function automatic void load(input logic [1:0] o, input logic [7:0] i);
        logic [23:0] lda, add, mov;
        lda = mk(1'b1, 1'b0, 6'b100000, 8'h00, i);
        add = mk(1'b1, 1'b0, 6'b001100, i, 8'h00);
        mov = mk(1'b1, 1'b0, 6'b010001, 8'h00, 8'h00);
        case (o)
            2'b00: sched.push_back(lda);
            2'b01: begin sched.push_back(add); sched.push_back(mov); end
            2'b10: begin sched.push_back(lda); sched.push_back(add); sched.push_back(mov); end
            default: sched.push_back(mov);
        endcase
        sched.push_back(mk(1'b0, 1'b1, 6'b000000, 8'h00, 8'h00));
    endfunction

    always @(posedge clock or negedge clear) begin
        logic [23:0] w;
        if (!clear) begin
            sched.delete();
            cnt <= 0;
        end else if (sched.size() != 0) begin
            w = sched.pop_front();
            if (w[22]) cnt <= cnt + 1;
        end else if (start) begin
            load(op, imm);
        end
    end

    // Small datapath fed by the strobes, used to confirm end-to-end effect.
    logic [7:0] dp_a, dp_b, dp_z, bus;
    assign bus = RAout ? dp_a : (RZout ? dp_z : (RBout ? dp_b : 8'h00));
    always @(posedge clock) begin
        if (RAin) dp_a <= RegisterAImmediate;
        if (RZin) dp_z <= bus + AddImmediate;
        if (RBin) dp_b <= bus;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [23:0] exp;
        int nb;
        wait (started);
        forever begin
            @(negedge clock);
            exp = (sched.size() == 0) ? 24'h0 : sched[0];
            chk("outputs", {8'h0, dut_vec}, {8'h0, exp});
            chk("small_outputs", {8'h0, small_vec}, {8'h0, exp});
            chk("op_count", {16'h0, op_count}, (cnt > 65535) ? 32'd65535 : cnt);
            chk("op_count_sat", {30'h0, s_op_count}, (cnt > 3) ? 32'd3 : cnt);
            nb = int'(RAout) + int'(RBout) + int'(RZout);
            chk("bus_exclusive", {31'h0, nb <= 1}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] i);
        op = o;
        imm = i;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8 && done !== 1'b1; c++) tick();
        chk("done_seen", {31'h0, done}, 32'd1);
        tick();
    endtask

    initial begin
        clear = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        imm   = 8'h00;
        tick();
        started = 1;
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_vec", {8'h0, dut_vec}, 32'd0);
        chk("reset_count", {16'h0, op_count}, 32'd0);
        clear = 1'b1;
        tick();

        // LDA imm 05
        op = 2'b00; imm = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lda_t0_rain", {31'h0, RAin}, 32'd1);
        chk("lda_t0_rai", {24'h0, RegisterAImmediate}, 32'h05);
        chk("lda_t0_busy", {31'h0, busy}, 32'd1);
        tick();
        chk("lda_done", {31'h0, done}, 32'd1);
        tick();
        chk("lda_count", {16'h0, op_count}, 32'd1);

        // LDADDB imm 05: B must end at 0A
        op = 2'b10; imm = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ldaddb_t0", {8'h0, dut_vec}, 32'hA0_0005);
        tick();
        chk("ldaddb_t1", {8'h0, dut_vec}, 32'h8C_0500);
        tick();
        chk("ldaddb_t2", {8'h0, dut_vec}, 32'h91_0000);
        tick();
        chk("ldaddb_done", {31'h0, done}, 32'd1);
        chk("datapath_b", {24'h0, dp_b}, 32'h0A);
        tick();

        // ADDB with start held and imm changed while busy
        op = 2'b01; imm = 8'h33; start = 1'b1;
        tick();
        imm = 8'hFF;
        #1;
        chk("addb_latched_imm", {24'h0, AddImmediate}, 32'h33);
        tick();
        chk("addb_t1_rzout", {31'h0, RZout}, 32'd1);
        chk("addb_t1_addimm", {24'h0, AddImmediate}, 32'h00);
        tick();
        chk("addb_done", {31'h0, done}, 32'd1);
        tick();
        chk("addb_idle_busy", {31'h0, busy}, 32'd0);
        tick();
        chk("addb_restart_busy", {31'h0, busy}, 32'd1);
        chk("addb_restart_imm", {24'h0, AddImmediate}, 32'hFF);
        start = 1'b0;
        tick();
        tick();
        tick();

        // Reset during T1 of LDADDB
        op = 2'b10; imm = 8'h21; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clear = 1'b0;
        #1;
        chk("rst_mid_vec", {8'h0, dut_vec}, 32'd0);
        chk("rst_mid_count", {16'h0, op_count}, 32'd0);
        tick();
        chk("rst_mid_no_done", {31'h0, done}, 32'd0);
        clear = 1'b1;
        tick();
        op = 2'b00; imm = 8'h07; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_after_rai", {24'h0, RegisterAImmediate}, 32'h07);
        tick();
        tick();

        // All four ops back to back from a clean count
        clear = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        for (int o = 0; o < 4; o++) run_op(2'(o), 8'($urandom));
        chk("b2b_count", {16'h0, op_count}, 32'd4);
        chk("b2b_small_sat", {30'h0, s_op_count}, 32'd3);

        // Random traffic with occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom);
            imm   = 8'($urandom);
            if ($urandom_range(0, 199) == 0) clear = 1'b0;
            tick();
            clear = 1'b1;
        end
        start = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
